hc_sr_scheduler: RTL
====================

# hc_sr_scheduler

Round-robin measurement scheduler for up to N HC-SR04 ultrasonic sensors sharing one echo-timing datapath. It fires each enabled sensor's trigger in turn, times that sensor's echo pulse in 1 µs ticks, converts the pulse width to distance (cm × 1000, three implied decimals), and enforces an inter-shot guard gap so sensors do not pick up each other's echoes. It sits between the sensor pins and the display/UART consumers, and replaces per-sensor free-running trigger logic.

## Interface
- N_SENSOR, 4, number of sensor channels (1–8)
- CLK_DIV, 50, Clk cycles per 1 µs tick (50 MHz)
- TRIG_US, 10, trigger pulse width in µs
- TIMEOUT_US, 30000, maximum wait for echo rise, and maximum echo high time, in µs
- GAP_US, 60000, guard time after each shot in µs
- Clk  in  1  system clock, 50 MHz
- Rst  in  1  asynchronous, active-high reset
- enable  in  1  run continuous round-robin while high
- chan_mask  in  N_SENSOR  1 = channel participates
- echo  in  N_SENSOR  raw echo pins (asynchronous)
- trig  out  N_SENSOR  trigger pins, at most one high at a time
- dist_o  out  19  last distance, cm × 1000
- chan_o  out  3  channel of last result
- timeout_o  out  1  last result was a timeout
- valid_o  out  1  one-cycle pulse: new result on dist_o/chan_o/timeout_o
- busy_o  out  1  high in any state except IDLE

## Operation
- Each echo bit passes through a 2-FF synchronizer; only the selected channel's synchronized echo is used.
- Internal µs prescaler (0..CLK_DIV-1) restarts at every state entry; the µs counter (16 bits) clears at every state entry and increments once per tick.
- States:
  - IDLE: trig = 0. If enable = 1 and chan_mask ≠ 0, select the next channel → TRIG. Otherwise stay.
  - TRIG: trig[ch] = 1 for exactly TRIG_US × CLK_DIV cycles → WAIT_RISE.
  - WAIT_RISE: on echo rise → MEASURE. After TIMEOUT_US µs with no rise → DONE with timeout.
  - MEASURE: counts µs while echo is high. On echo fall → DONE. At TIMEOUT_US µs → DONE with timeout.
  - DONE: one cycle; registers the result → GAP.
  - GAP: waits GAP_US µs → IDLE.
- Next channel: the lowest enabled index strictly greater than the last channel, wrapping to the lowest enabled index. After reset, the search starts from index 0. chan_mask is sampled only in IDLE.
- Distance arithmetic: dist = echo_us × 17, computed as (us << 4) + us and truncated to 19 bits. With TIMEOUT_US ≤ 30840 the result cannot overflow.
- Timeout result: dist_o = 19'h7FFFF, timeout_o = 1.
- enable is checked only in IDLE. If enable falls mid-shot, the shot and GAP still complete, then the block parks in IDLE.
- Any mask change mid-shot has no effect until IDLE.

## Timing
- Reset values: trig = 0, dist_o = 0, chan_o = 0, timeout_o = 0, valid_o = 0, busy_o = 0, state = IDLE, last channel = N_SENSOR-1.
- Reset mid-operation: trig drops in the same cycle (asynchronous), and no partial result is emitted.
- Trigger start: trig rises 1 cycle after the IDLE → TRIG decision. Width is exactly TRIG_US × CLK_DIV cycles.
- Echo latency: 2 cycles of synchronizer, plus 1 cycle of edge detect, plus 1 cycle in DONE. valid_o, dist_o, chan_o and timeout_o update together on the first GAP cycle.
- valid_o is high for exactly 1 cycle. The data outputs hold until the next valid_o.
- Resolution: the result is the count of completed µs ticks, so it truncates by up to 1 µs plus synchronizer delay.
- An echo already high on entering WAIT_RISE is not counted as a rise. A fresh 0 → 1 transition is required.
- busy_o is low only in IDLE.

## Test plan
- Reset, enable = 1, mask = 4'b0001. Echo0 rises 100 µs after trig falls and stays high 1000 µs. Expected: trig[0] is 500 cycles wide; valid_o pulses once with dist_o = 17000, chan_o = 0, timeout_o = 0. The next trig[0] comes only after the 60000 µs gap.
- mask = 4'b1010, echo = 580 µs on each channel. Expected: trig order 1, 3, 1, 3; every result dist_o = 9860; trig[0] and trig[2] never assert.
- No echo rise on channel 2, mask = 4'b0100. Expected: valid_o after 30000 µs in WAIT_RISE, with dist_o = 19'h7FFFF and timeout_o = 1. Same result when echo is stuck high for more than 30000 µs in MEASURE.
- enable deasserted mid-MEASURE. Expected: the result is still delivered, GAP is completed, then IDLE with busy_o = 0. Reasserting enable resumes at the next channel in order.
- Rst pulsed mid-TRIG and mid-MEASURE. Expected: trig = 0 immediately, all outputs at their reset values, no valid_o. The first channel fired after release is the lowest enabled index.
- mask = 0 with enable = 1. Expected: stays in IDLE, trig = 0, busy_o = 0 indefinitely.

Source files
------------

// File: rtl/hc_sr_scheduler.sv
// Round-robin scheduler for up to N_SENSOR HC-SR04 sensors sharing one echo timer.
// Fires each enabled trigger in turn, times the echo in us ticks and reports cm x 1000.
module hc_sr_scheduler #(
  parameter int N_SENSOR   = 4,
  parameter int CLK_DIV    = 50,
  parameter int TRIG_US    = 10,
  parameter int TIMEOUT_US = 30000,
  parameter int GAP_US     = 60000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic [N_SENSOR-1:0] chan_mask,
  input  logic [N_SENSOR-1:0] echo,
  output logic [N_SENSOR-1:0] trig,
  output logic [18:0]         dist_o,
  output logic [2:0]          chan_o,
  output logic                timeout_o,
  output logic                valid_o,
  output logic                busy_o
);

  localparam int             PW           = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0]  PRESC_MAX    = PW'(CLK_DIV - 1);
  localparam logic [15:0]    TRIG_LAST    = 16'(TRIG_US - 1);
  localparam logic [15:0]    TIMEOUT_LAST = 16'(TIMEOUT_US - 1);
  localparam logic [15:0]    GAP_LAST     = 16'(GAP_US - 1);
  localparam logic [18:0]    DIST_TIMEOUT = 19'h7FFFF;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_TRIG      = 3'd1,
    ST_WAIT_RISE = 3'd2,
    ST_MEASURE   = 3'd3,
    ST_DONE      = 3'd4,
    ST_GAP       = 3'd5
  } state_t;

  // Distance = us * 17, built as (us << 4) + us and kept to 19 bits.
  function automatic logic [18:0] us_to_dist(input logic [15:0] us);
    return 19'({us, 4'b0000}) + {3'b000, us};
  endfunction

  state_t                state_r;
  state_t                state_nx_s;
  logic [N_SENSOR-1:0]   echo_meta_r;
  logic [N_SENSOR-1:0]   echo_sync_r;
  logic                  echo_prev_r;
  logic                  sel_echo_s;
  logic                  rise_s;
  logic [PW-1:0]         presc_r;
  logic [15:0]           us_r;
  logic                  tick_s;
  logic [2:0]            chan_r;
  logic [2:0]            chan_nx_s;
  logic [2:0]            lo_idx_s;
  logic [2:0]            hi_idx_s;
  logic                  hi_any_s;
  logic [2:0]            tgt_ch_s;
  logic [N_SENSOR-1:0]   trig_nx_s;
  logic                  cap_en_s;
  logic [15:0]           cap_us_s;
  logic                  cap_to_s;
  logic [15:0]           res_us_r;
  logic                  res_to_r;
  logic [N_SENSOR-1:0]   trig_r;
  logic [18:0]           dist_r;
  logic [2:0]            chan_out_r;
  logic                  to_r;
  logic                  valid_r;
  logic                  busy_r;

  assign tick_s = (presc_r == PRESC_MAX);
  assign rise_s = sel_echo_s & ~echo_prev_r;

  // Two-flop synchronizer on every echo pin plus a delayed copy of the selected one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      echo_meta_r <= {N_SENSOR{1'b0}};
      echo_sync_r <= {N_SENSOR{1'b0}};
      echo_prev_r <= 1'b0;
    end else begin
      echo_meta_r <= echo;
      echo_sync_r <= echo_meta_r;
      echo_prev_r <= sel_echo_s;
    end
  end

  // Pick the synchronized echo of the channel currently being served.
  always_comb begin
    sel_echo_s = 1'b0;
    for (int i = 0; i < N_SENSOR; i++) begin
      sel_echo_s = (chan_r == 3'(i)) ? echo_sync_r[i] : sel_echo_s;
    end
  end

  // Next channel: lowest enabled index above the last one, else the lowest enabled.
  always_comb begin
    lo_idx_s = 3'd0;
    hi_idx_s = 3'd0;
    hi_any_s = 1'b0;
    for (int i = N_SENSOR - 1; i >= 0; i--) begin
      lo_idx_s = chan_mask[i] ? 3'(i) : lo_idx_s;
      hi_idx_s = (chan_mask[i] && (3'(i) > chan_r)) ? 3'(i) : hi_idx_s;
      hi_any_s = (chan_mask[i] && (3'(i) > chan_r)) ? 1'b1 : hi_any_s;
    end
    chan_nx_s = hi_any_s ? hi_idx_s : lo_idx_s;
  end

  // Next-state logic and result capture on leaving WAIT_RISE / MEASURE.
  always_comb begin
    state_nx_s = state_r;
    cap_en_s   = 1'b0;
    cap_us_s   = us_r;
    cap_to_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (enable && (chan_mask != {N_SENSOR{1'b0}})) state_nx_s = ST_TRIG;
        else                                            state_nx_s = ST_IDLE;
      end
      ST_TRIG: begin
        if (tick_s && (us_r == TRIG_LAST)) state_nx_s = ST_WAIT_RISE;
        else                               state_nx_s = ST_TRIG;
      end
      ST_WAIT_RISE: begin
        if (rise_s) begin
          state_nx_s = ST_MEASURE;
        end else if (tick_s && (us_r == TIMEOUT_LAST)) begin
          state_nx_s = ST_DONE;
          cap_en_s   = 1'b1;
          cap_to_s   = 1'b1;
        end else begin
          state_nx_s = ST_WAIT_RISE;
        end
      end
      ST_MEASURE: begin
        // Count the tick completing in this cycle so a full final us is not lost.
        if (!sel_echo_s) begin
          state_nx_s = ST_DONE;
          cap_en_s   = 1'b1;
          cap_us_s   = us_r + {15'd0, tick_s};
        end else if (tick_s && (us_r == TIMEOUT_LAST)) begin
          state_nx_s = ST_DONE;
          cap_en_s   = 1'b1;
          cap_to_s   = 1'b1;
        end else begin
          state_nx_s = ST_MEASURE;
        end
      end
      ST_DONE: begin
        state_nx_s = ST_GAP;
      end
      ST_GAP: begin
        if (tick_s && (us_r == GAP_LAST)) state_nx_s = ST_IDLE;
        else                              state_nx_s = ST_GAP;
      end
      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase
  end

  // Trigger pattern for the coming cycle; only the served channel can be high.
  always_comb begin
    tgt_ch_s  = (state_r == ST_IDLE) ? chan_nx_s : chan_r;
    trig_nx_s = {N_SENSOR{1'b0}};
    for (int i = 0; i < N_SENSOR; i++) begin
      trig_nx_s[i] = (state_nx_s == ST_TRIG) && (tgt_ch_s == 3'(i));
    end
  end

  // State register and served channel, latched on the IDLE -> TRIG decision.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      chan_r  <= 3'(N_SENSOR - 1);
    end else begin
      state_r <= state_nx_s;
      if ((state_r == ST_IDLE) && (state_nx_s == ST_TRIG)) chan_r <= chan_nx_s;
      else                                                  chan_r <= chan_r;
    end
  end

  // Prescaler and us counter, both restarting on every state entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_r <= {PW{1'b0}};
      us_r    <= 16'd0;
    end else if (state_nx_s != state_r) begin
      presc_r <= {PW{1'b0}};
      us_r    <= 16'd0;
    end else if (tick_s) begin
      presc_r <= {PW{1'b0}};
      us_r    <= us_r + 16'd1;
    end else begin
      presc_r <= presc_r + PW'(1);
      us_r    <= us_r;
    end
  end

  // Measurement result held between the end of timing and DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_us_r <= 16'd0;
      res_to_r <= 1'b0;
    end else if (cap_en_s) begin
      res_us_r <= cap_us_s;
      res_to_r <= cap_to_s;
    end else begin
      res_us_r <= res_us_r;
      res_to_r <= res_to_r;
    end
  end

  // Registered outputs; the result lands together with valid on the first GAP cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      trig_r     <= {N_SENSOR{1'b0}};
      dist_r     <= 19'd0;
      chan_out_r <= 3'd0;
      to_r       <= 1'b0;
      valid_r    <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      trig_r  <= trig_nx_s;
      busy_r  <= (state_nx_s != ST_IDLE);
      valid_r <= (state_r == ST_DONE);
      if (state_r == ST_DONE) begin
        dist_r     <= res_to_r ? DIST_TIMEOUT : us_to_dist(res_us_r);
        chan_out_r <= chan_r;
        to_r       <= res_to_r;
      end else begin
        dist_r     <= dist_r;
        chan_out_r <= chan_out_r;
        to_r       <= to_r;
      end
    end
  end

  assign trig      = trig_r;
  assign dist_o    = dist_r;
  assign chan_o    = chan_out_r;
  assign timeout_o = to_r;
  assign valid_o   = valid_r;
  assign busy_o    = busy_r;

endmodule
